// File: rtl/vga_sync_rx_if.sv
// vga_sync_rx_if: sync-input / timing-output bundle of the VGA sync receiver.
//   hs_in, vs_in       raw active-low syncs (driven by the source side)
//   hs_pulse, vs_pulse 1-cycle line / frame start strobes
//   x_out, y_out       pixel coordinates since line / frame start
//   line_len           last measured line length (clocks)
//   frame_lines        last measured frame height (lines)
//   locked             timing stable
//   err_cnt            LOCKED->SEARCH event count (only with VGA_SYNC_RX_ERRCNT_EN)
// master = sync source / consumer side, slave = vga_sync_rx.
interface vga_sync_rx_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  logic          hs_in;
  logic          vs_in;
  logic          hs_pulse;
  logic          vs_pulse;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [XW-1:0] line_len;
  logic [YW-1:0] frame_lines;
  logic          locked;
`ifdef VGA_SYNC_RX_ERRCNT_EN
  logic [7:0]    err_cnt;

  modport master (output hs_in, vs_in,
                  input  hs_pulse, vs_pulse, x_out, y_out, line_len, frame_lines, locked,
                         err_cnt);
  modport slave  (input  hs_in, vs_in,
                  output hs_pulse, vs_pulse, x_out, y_out, line_len, frame_lines, locked,
                         err_cnt);
`else
  modport master (output hs_in, vs_in,
                  input  hs_pulse, vs_pulse, x_out, y_out, line_len, frame_lines, locked);
  modport slave  (input  hs_in, vs_in,
                  output hs_pulse, vs_pulse, x_out, y_out, line_len, frame_lines, locked);
`endif
endinterface

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers line/frame timing from raw active-low hsync/vsync, measures
// line length and frame height, locks once both are stable and reports pixel coordinates.
// Ports:
//   clk    pixel clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    vga_sync_rx_if.slave (syncs in; strobes, coordinates, measurements, lock out)
// Optional: define VGA_SYNC_RX_ERRCNT_EN to add bus.err_cnt, a saturating count of
// LOCKED->SEARCH transitions, cleared only by rst_n.
module vga_sync_rx #(
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_sync_rx_if.slave  bus
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [XW-1:0] XMAX = '1;
  localparam logic [YW-1:0] YMAX = '1;

  // [0]/[1] = synchroniser, [2] = history; idle (high) out of reset
  logic [2:0]    r_hs_sh, r_vs_sh;
  logic          r_hsp, r_vsp, r_pend;
  logic [XW-1:0] r_hcnt, r_len, r_ref_len;
  logic [YW-1:0] r_vcnt, r_flines, r_prev_lines;
  state_t        r_state;
  logic          r_locked, r_ref_ok, r_prev_ok, r_bad;
  logic [15:0]   r_cnt;

  logic          w_hfall, w_vfall, w_fstart, w_htmo, w_vtmo;
  logic          w_line_ok, w_frm_ok;
  logic [XW-1:0] w_len;
  logic [YW-1:0] w_flines;
  logic [15:0]   w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_sh <= '1;
      r_vs_sh <= '1;
    end else begin
      r_hs_sh <= {r_hs_sh[1:0], bus.hs_in};
      r_vs_sh <= {r_vs_sh[1:0], bus.vs_in};
    end
  end

  assign w_hfall   = r_hs_sh[2] & ~r_hs_sh[1];
  assign w_vfall   = r_vs_sh[2] & ~r_vs_sh[1];
  // a vsync fall starts the frame on the same line start or, if it came mid-line,
  // on the next one
  assign w_fstart  = w_hfall & (w_vfall | r_pend);
  assign w_len     = r_hcnt + XW'(1);
  assign w_flines  = r_vcnt + YW'(1);
  assign w_htmo    = ~w_hfall & (r_hcnt == XMAX);
  assign w_vtmo    = w_hfall & ~w_fstart & (r_vcnt == YMAX);
  // before a reference exists the first measurement is accepted and becomes it
  assign w_line_ok = ~r_ref_ok  | (w_len == r_ref_len);
  assign w_frm_ok  = ~r_prev_ok | (w_flines == r_prev_lines);
  assign w_cnt_nxt = r_cnt + 16'd1;

  // line/frame counters and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt   <= '0;
      r_vcnt   <= '0;
      r_len    <= '0;
      r_flines <= '0;
      r_pend   <= 1'b0;
      r_hsp    <= 1'b0;
      r_vsp    <= 1'b0;
    end else begin
      r_hsp <= w_hfall;
      r_vsp <= w_fstart;
      if (w_hfall) begin
        r_hcnt <= '0;
        r_len  <= w_len;
      end else if (!w_htmo) begin
        r_hcnt <= r_hcnt + XW'(1);
      end
      if (w_fstart) begin
        r_vcnt   <= '0;
        r_flines <= w_flines;
        r_pend   <= 1'b0;
      end else begin
        if (w_vfall)             r_pend <= 1'b1;
        if (w_hfall && !w_vtmo)  r_vcnt <= r_vcnt + YW'(1);
      end
    end
  end

`ifdef VGA_SYNC_RX_ERRCNT_EN
  logic [7:0] r_err;
`endif

  // lock FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= SEARCH;
      r_locked     <= 1'b0;
      r_ref_len    <= '0;
      r_ref_ok     <= 1'b0;
      r_prev_lines <= '0;
      r_prev_ok    <= 1'b0;
      r_bad        <= 1'b0;
      r_cnt        <= '0;
`ifdef VGA_SYNC_RX_ERRCNT_EN
      r_err        <= '0;
`endif
    end else begin
      case (r_state)
        SEARCH: begin
          if (w_fstart) begin
            r_state   <= MEASURE;
            r_ref_ok  <= 1'b0;
            r_prev_ok <= 1'b0;
            r_bad     <= 1'b0;
            r_cnt     <= '0;
          end
        end
        MEASURE: begin
          if (w_htmo || w_vtmo) begin
            r_state <= SEARCH;
          end else if (w_hfall) begin
            // the latest line length is always the reference going forward
            r_ref_len <= w_len;
            r_ref_ok  <= 1'b1;
            if (w_fstart) begin
              r_prev_lines <= w_flines;
              r_prev_ok    <= 1'b1;
              r_bad        <= 1'b0;
              if (r_bad || !w_line_ok || !w_frm_ok) begin
                r_cnt <= '0;
              end else if (int'(w_cnt_nxt) >= LOCK_FRAMES) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_cnt    <= '0;
              end else begin
                r_cnt <= w_cnt_nxt;
              end
            end else if (!w_line_ok) begin
              // frame in progress no longer counts toward lock
              r_bad <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (w_htmo || w_vtmo || (w_hfall && !w_line_ok) || (w_fstart && !w_frm_ok)) begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
`ifdef VGA_SYNC_RX_ERRCNT_EN
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
`endif
          end
        end
        default: begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hs_pulse    = r_hsp;
  assign bus.vs_pulse    = r_vsp;
  assign bus.x_out       = r_hcnt;
  assign bus.y_out       = r_vcnt;
  assign bus.line_len    = r_len;
  assign bus.frame_lines = r_flines;
  assign bus.locked      = r_locked;
`ifdef VGA_SYNC_RX_ERRCNT_EN
  assign bus.err_cnt     = r_err;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: directed bench for vga_sync_rx. A cycle table covers sync latency and
// deferred frame start; hand sequences cover lock, line mismatch, timeout and async reset
// using a small 40-clock x 6-line test raster (hs low 4 clocks, vs low for line 0).
module tb_vga_sync_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_sync_rx_if #(.XW(10), .YW(9)) bus ();

  vga_sync_rx #(.XW(10), .YW(9), .LOCK_FRAMES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       hs, vs;
    logic       e_hsp, e_vsp;
    logic [9:0] e_x;
    logic [8:0] e_y;
    logic [9:0] e_len;
    logic [8:0] e_fl;
    logic       e_lk;
  } vec_t;

  vec_t tv[15];

  int   n_chk = 0;
  int   n_err = 0;
  int   vs_cnt = 0;
  logic vs_lk[16];
  logic hsp_lk, hsp_prev_lk, prev_lk, sat_lk;
  logic [9:0] hsp_len, prev_x;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int hs, vs, hsp, vsp, x, y, len, fl, lk);
    vec_t v;
    v.hs = hs[0]; v.vs = vs[0]; v.e_hsp = hsp[0]; v.e_vsp = vsp[0];
    v.e_x = x[9:0]; v.e_y = y[8:0]; v.e_len = len[9:0]; v.e_fl = fl[8:0]; v.e_lk = lk[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // one clock edge, then sample and record events
  task automatic step();
    @(posedge clk); #1;
    if (bus.vs_pulse) begin
      if (vs_cnt < 16) vs_lk[vs_cnt] = bus.locked;
      vs_cnt++;
    end
    if (bus.hs_pulse) begin
      hsp_lk = bus.locked; hsp_prev_lk = prev_lk; hsp_len = bus.line_len;
    end
    if (bus.x_out == 10'd1023 && prev_x != 10'd1023) sat_lk = bus.locked;
    prev_lk = bus.locked;
    prev_x  = bus.x_out;
  endtask

  task automatic drive(input logic hs, input logic vs);
    bus.hs_in = hs;
    bus.vs_in = vs;
    step();
  endtask

  task automatic run_line(input int len, input logic vs_low);
    for (int c = 0; c < len; c++) drive((c < 4) ? 1'b0 : 1'b1, ~vs_low);
  endtask

  task automatic run_frame();
    for (int l = 0; l < 6; l++) run_line(40, l == 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".hsp"}, 32'(bus.hs_pulse), 0);
    chk({nm, ".vsp"}, 32'(bus.vs_pulse), 0);
    chk({nm, ".x"},   32'(bus.x_out), 0);
    chk({nm, ".y"},   32'(bus.y_out), 0);
    chk({nm, ".len"}, 32'(bus.line_len), 0);
    chk({nm, ".fl"},  32'(bus.frame_lines), 0);
    chk({nm, ".lk"},  32'(bus.locked), 0);
`ifdef VGA_SYNC_RX_ERRCNT_EN
    chk({nm, ".err"}, 32'(bus.err_cnt), 0);
`endif
  endtask

  // three clean frames from an unlocked state: locked must rise with the 3rd vs_pulse
  task automatic lock_seq(input string nm);
    vs_cnt = 0;
    for (int f = 0; f < 16; f++) vs_lk[f] = 1'bx;
    for (int f = 0; f < 3; f++) run_frame();
    chk({nm, ".vs_n"}, 32'(vs_cnt), 3);
    chk({nm, ".lk@vs1"}, 32'(vs_lk[0]), 0);
    chk({nm, ".lk@vs2"}, 32'(vs_lk[1]), 0);
    chk({nm, ".lk@vs3"}, 32'(vs_lk[2]), 1);
    chk({nm, ".len"}, 32'(bus.line_len), 40);
    chk({nm, ".fl"},  32'(bus.frame_lines), 6);
    chk({nm, ".lk_end"}, 32'(bus.locked), 1);
  endtask

  initial begin
    // hs, vs -> hs_pulse, vs_pulse, x, y, line_len, frame_lines, locked (after the edge)
    // hs low sampled at edge 3 -> pulse after edge 5; vs low sampled at edge 7,
    // hs low at edge 12 -> vs_pulse deferred to the hs_pulse after edge 14
    tv[0]  = mk(1, 1, 0, 0, 1, 0, 0, 0, 0);
    tv[1]  = mk(1, 1, 0, 0, 2, 0, 0, 0, 0);
    tv[2]  = mk(0, 1, 0, 0, 3, 0, 0, 0, 0);
    tv[3]  = mk(0, 1, 0, 0, 4, 0, 0, 0, 0);
    tv[4]  = mk(0, 1, 1, 0, 0, 1, 5, 0, 0);
    tv[5]  = mk(1, 1, 0, 0, 1, 1, 5, 0, 0);
    tv[6]  = mk(1, 0, 0, 0, 2, 1, 5, 0, 0);
    tv[7]  = mk(1, 0, 0, 0, 3, 1, 5, 0, 0);
    tv[8]  = mk(1, 1, 0, 0, 4, 1, 5, 0, 0);
    tv[9]  = mk(1, 1, 0, 0, 5, 1, 5, 0, 0);
    tv[10] = mk(1, 1, 0, 0, 6, 1, 5, 0, 0);
    tv[11] = mk(0, 1, 0, 0, 7, 1, 5, 0, 0);
    tv[12] = mk(0, 1, 0, 0, 8, 1, 5, 0, 0);
    tv[13] = mk(0, 1, 1, 1, 0, 0, 9, 2, 0);
    tv[14] = mk(1, 1, 0, 0, 1, 0, 9, 2, 0);

    hsp_lk = 1'b0; hsp_prev_lk = 1'b0; prev_lk = 1'b0; sat_lk = 1'b0;
    hsp_len = '0; prev_x = '0;
    bus.hs_in = 1'b1;
    bus.vs_in = 1'b1;

    #12;
    chk_zero("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tv[i].hs, tv[i].vs);
      chk($sformatf("tv%0d.hsp", i), 32'(bus.hs_pulse),    32'(tv[i].e_hsp));
      chk($sformatf("tv%0d.vsp", i), 32'(bus.vs_pulse),    32'(tv[i].e_vsp));
      chk($sformatf("tv%0d.x", i),   32'(bus.x_out),       32'(tv[i].e_x));
      chk($sformatf("tv%0d.y", i),   32'(bus.y_out),       32'(tv[i].e_y));
      chk($sformatf("tv%0d.len", i), 32'(bus.line_len),    32'(tv[i].e_len));
      chk($sformatf("tv%0d.fl", i),  32'(bus.frame_lines), 32'(tv[i].e_fl));
      chk($sformatf("tv%0d.lk", i),  32'(bus.locked),      32'(tv[i].e_lk));
    end

    // clean lock from reset
    rst_n = 1'b0;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    rst_n = 1'b1;
    lock_seq("t1");

    // one 39-clock line while locked
    run_line(40, 1'b1);
    run_line(40, 1'b0);
    run_line(39, 1'b0);
    run_line(40, 1'b0);
    chk("t3.len", 32'(hsp_len), 39);
    chk("t3.lk_before", 32'(hsp_prev_lk), 1);
    chk("t3.lk@hsp", 32'(hsp_lk), 0);
`ifdef VGA_SYNC_RX_ERRCNT_EN
    chk("t3.err", 32'(bus.err_cnt), 1);
`endif
    run_line(40, 1'b0);
    run_line(40, 1'b0);
    lock_seq("t3r");

    // hsync stuck high while locked
    for (int c = 0; c < 1100; c++) drive(1'b1, 1'b1);
    chk("t4.lk@1023", 32'(sat_lk), 1);
    chk("t4.lk", 32'(bus.locked), 0);
    chk("t4.x", 32'(bus.x_out), 1023);
    chk("t4.y", 32'(bus.y_out), 5);
`ifdef VGA_SYNC_RX_ERRCNT_EN
    chk("t4.err", 32'(bus.err_cnt), 2);
`endif
    lock_seq("t4r");

    // async reset mid-line while locked
    for (int c = 0; c < 15; c++) drive((c < 4) ? 1'b0 : 1'b1, 1'b0);
    chk("t6.lk_pre", 32'(bus.locked), 1);
    rst_n = 1'b0;
    #2;
    chk_zero("t6");
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    rst_n = 1'b1;
    lock_seq("t6r");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
